// File: rtl/slave_result_arbiter.sv
// Round-robin arbiter that shares the single slave-to-master result path between three slave cores.
// The winner's result is latched, handed to the master with req/ack, then the slave is released via S_grant.
module slave_result_arbiter #(
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              Clock_pin,
   input  logic              Reset_pin,
   input  logic [2:0]        S_req,
   input  logic [DATA_W-1:0] S_data0,
   input  logic [DATA_W-1:0] S_data1,
   input  logic [DATA_W-1:0] S_data2,
   output logic [2:0]        S_grant,
   output logic              M_req,
   output logic [DATA_W-1:0] M_data,
   output logic [1:0]        M_id,
   input  logic              M_ack,
   output logic              Busy,
   output logic              Timeout_err,
   output logic [1:0]        Err_id
);

   typedef enum logic [1:0] {IDLE, CAPTURE, PRESENT, RELEASE} state_t;

   localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYC);

   state_t            state, state_n;
   logic [1:0]        last, last_n;
   logic [1:0]        winner, winner_n;
   logic [15:0]       wdog, wdog_n;
   logic [2:0]        grant_n;
   logic              mreq_n;
   logic [DATA_W-1:0] mdata_n;
   logic [1:0]        mid_n;
   logic              terr_n;
   logic [1:0]        errid_n;
   logic [DATA_W-1:0] win_data;
   logic              wd_expire;
   logic [15:0]       wd_inc;

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   // Search order is last+1, last+2, last so the previous winner has lowest priority.
   function automatic logic [1:0] rr_pick(input logic [1:0] last_q, input logic [2:0] req);
      logic [1:0] c1;
      logic [1:0] c2;
      c1 = next_idx(last_q);
      c2 = next_idx(c1);
      if (req[c1])      return c1;
      else if (req[c2]) return c2;
      else              return last_q;
   endfunction

   always_comb begin
      case (winner)
         2'd0:    win_data = S_data0;
         2'd1:    win_data = S_data1;
         default: win_data = S_data2;
      endcase
   end

   // A zero timeout disables the watchdog; the counter itself saturates so it never wraps.
   assign wd_expire = (TIMEOUT_W != 16'd0) && (wdog >= TIMEOUT_W - 16'd1);
   assign wd_inc    = (wdog == 16'hFFFF) ? wdog : wdog + 16'd1;
   assign Busy      = (state != IDLE);

   // NOTE: every next-state variable gets its hold value first so no path can infer a latch.
   always_comb begin
      state_n  = state;
      last_n   = last;
      winner_n = winner;
      wdog_n   = wdog;
      grant_n  = S_grant;
      mreq_n   = M_req;
      mdata_n  = M_data;
      mid_n    = M_id;
      terr_n   = Timeout_err;
      errid_n  = Err_id;
      case (state)
         IDLE: begin
            if (S_req != 3'b000) begin
               winner_n = rr_pick(last, S_req);
               state_n  = CAPTURE;
            end
         end
         CAPTURE: begin
            if (S_req[winner]) begin
               mdata_n = win_data;
               mid_n   = winner;
               mreq_n  = 1'b1;
               wdog_n  = 16'd0;
               state_n = PRESENT;
            end else begin
               state_n = IDLE;
            end
         end
         PRESENT: begin
            if (M_ack) begin
               mreq_n  = 1'b0;
               grant_n = 3'b001 << winner;
               wdog_n  = 16'd0;
               state_n = RELEASE;
            end else if (wd_expire) begin
               mreq_n  = 1'b0;
               terr_n  = 1'b1;
               errid_n = winner;
               grant_n = 3'b001 << winner;
               wdog_n  = 16'd0;
               state_n = RELEASE;
            end else begin
               wdog_n = wd_inc;
            end
         end
         RELEASE: begin
            if (!S_req[winner]) begin
               grant_n = 3'b000;
               last_n  = winner;
               state_n = IDLE;
            end else if (wd_expire) begin
               grant_n = 3'b000;
               terr_n  = 1'b1;
               errid_n = winner;
               last_n  = winner;
               state_n = IDLE;
            end else begin
               wdog_n = wd_inc;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge Clock_pin) begin
      if (Reset_pin) begin
         state       <= IDLE;
         last        <= 2'd2;
         winner      <= 2'd0;
         wdog        <= 16'd0;
         S_grant     <= 3'b000;
         M_req       <= 1'b0;
         M_data      <= '0;
         M_id        <= 2'd0;
         Timeout_err <= 1'b0;
         Err_id      <= 2'd0;
      end else begin
         state       <= state_n;
         last        <= last_n;
         winner      <= winner_n;
         wdog        <= wdog_n;
         S_grant     <= grant_n;
         M_req       <= mreq_n;
         M_data      <= mdata_n;
         M_id        <= mid_n;
         Timeout_err <= terr_n;
         Err_id      <= errid_n;
      end
   end

endmodule

// File: tb/tb_slave_result_arbiter.sv
// Scoreboard bench for slave_result_arbiter: one instance with a short watchdog, one with it disabled.
module tb_slave_result_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] s_req, s_req_b;
   logic [7:0] s_data0, s_data1, s_data2;
   logic       m_ack, m_ack_b;

   logic [2:0] s_grant, s_grant_b;
   logic       m_req, m_req_b;
   logic [7:0] m_data, m_data_b;
   logic [1:0] m_id, m_id_b;
   logic       busy, busy_b;
   logic       terr, terr_b;
   logic [1:0] err_id, err_id_b;

   always #5 clk = ~clk;

   slave_result_arbiter #(.DATA_W(8), .TIMEOUT_CYC(4)) dut (
      .Clock_pin(clk), .Reset_pin(rst), .S_req(s_req),
      .S_data0(s_data0), .S_data1(s_data1), .S_data2(s_data2),
      .S_grant(s_grant), .M_req(m_req), .M_data(m_data), .M_id(m_id),
      .M_ack(m_ack), .Busy(busy), .Timeout_err(terr), .Err_id(err_id)
   );

   slave_result_arbiter #(.DATA_W(8), .TIMEOUT_CYC(0)) dut_nowd (
      .Clock_pin(clk), .Reset_pin(rst), .S_req(s_req_b),
      .S_data0(s_data0), .S_data1(s_data1), .S_data2(s_data2),
      .S_grant(s_grant_b), .M_req(m_req_b), .M_data(m_data_b), .M_id(m_id_b),
      .M_ack(m_ack_b), .Busy(busy_b), .Timeout_err(terr_b), .Err_id(err_id_b)
   );

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } txn_t;

   txn_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic mon_prev = 1'b0;
   txn_t mon_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [1:0] id, input logic [7:0] d);
      txn_t t;
      t.id   = id;
      t.data = d;
      exp_q.push_back(t);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_mreq(input string name, input int budget);
      int n;
      n = 0;
      while (!m_req && n < budget) begin
         tick();
         n++;
      end
      check(name, m_req, 1);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      check(name, busy, 0);
   endtask

   // Behavioural master/slaves: master acks as soon as M_req is seen, a slave drops one cycle after its grant.
   task automatic run_auto(input string name, input int n_grants, input bit rearm, input logic [2:0] init_req);
      int got;
      int cyc;
      got   = 0;
      cyc   = 0;
      s_req = init_req;
      while (got < n_grants && cyc < 200) begin
         tick();
         cyc++;
         m_ack = m_req;
         for (int i = 0; i < 3; i++) begin
            if (s_grant[i]) begin
               if (s_req[i]) got++;
               s_req[i] = 1'b0;
            end else if (rearm && !s_req[i]) begin
               s_req[i] = 1'b1;
            end
         end
      end
      check(name, got, n_grants);
      s_req = 3'b000;
      m_ack = 1'b0;
      wait_idle({name, "_idle"}, 20);
   endtask

   // Monitor: pops the scoreboard on every new M_req and checks grant exclusivity.
   initial begin
      forever begin
         @(negedge clk);
         if (m_req && !mon_prev) begin
            if (exp_q.size() == 0) begin
               check("unexpected_mreq", 1, 0);
            end else begin
               mon_t = exp_q.pop_front();
               check("sb_id", m_id, mon_t.id);
               check("sb_data", m_data, mon_t.data);
            end
         end
         if (s_grant != 3'b000) begin
            check("grant_onehot", 32'($onehot(s_grant)), 1);
            check("grant_vs_mreq", m_req, 0);
         end
         mon_prev = m_req;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench time limit");
   end

   initial begin
      rst = 1'b1; s_req = 3'b000; s_req_b = 3'b000; m_ack = 1'b0; m_ack_b = 1'b0;
      s_data0 = 8'h00; s_data1 = 8'h00; s_data2 = 8'h00;
      tick();
      tick();
      check("rst_grant", s_grant, 0);
      check("rst_mreq", m_req, 0);
      check("rst_mdata", m_data, 0);
      check("rst_mid", m_id, 0);
      check("rst_busy", busy, 0);
      check("rst_terr", terr, 0);
      check("rst_errid", err_id, 0);
      rst = 1'b0;

      // Single request from slave 1
      s_data1 = 8'hA5;
      s_req   = 3'b010;
      push(2'd1, 8'hA5);
      tick();
      check("cap_busy", busy, 1);
      check("cap_no_mreq", m_req, 0);
      tick();
      check("single_mreq", m_req, 1);
      check("single_mdata", m_data, 8'hA5);
      check("single_mid", m_id, 1);
      tick();
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
      check("single_grant", s_grant, 3'b010);
      check("single_mreq_low", m_req, 0);
      tick();
      check("single_grant_hold", s_grant, 3'b010);
      s_req = 3'b000;
      tick();
      check("single_release", s_grant, 0);
      check("single_idle", busy, 0);

      // Fairness with all three requesting
      rst = 1'b1;
      tick();
      rst = 1'b0;
      s_data0 = 8'h10; s_data1 = 8'h20; s_data2 = 8'h30;
      push(2'd0, 8'h10); push(2'd1, 8'h20); push(2'd2, 8'h30); push(2'd0, 8'h10);
      run_auto("fair_grants", 4, 1'b1, 3'b111);

      // One-cycle withdrawal from slave 2, then slave 0 served
      s_req = 3'b100;
      tick();
      s_req = 3'b000;
      tick();
      check("withdraw_mreq", m_req, 0);
      check("withdraw_idle", busy, 0);
      tick();
      check("withdraw_mreq2", m_req, 0);
      s_data0 = 8'h77;
      push(2'd0, 8'h77);
      run_auto("after_withdraw", 1, 1'b0, 3'b001);

      // Reset while presenting; pointer must return to 2
      s_data1 = 8'h5C;
      push(2'd1, 8'h5C);
      s_req = 3'b010;
      wait_mreq("mid_mreq", 10);
      check("mid_mdata", m_data, 8'h5C);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      s_req = 3'b000;
      check("mid_rst_mreq", m_req, 0);
      check("mid_rst_mdata", m_data, 0);
      check("mid_rst_mid", m_id, 0);
      check("mid_rst_grant", s_grant, 0);
      check("mid_rst_busy", busy, 0);
      tick();
      check("mid_rst_nogrant", s_grant, 0);
      s_data0 = 8'h11; s_data1 = 8'h22;
      push(2'd0, 8'h11); push(2'd1, 8'h22);
      run_auto("post_rst_order", 2, 1'b0, 3'b011);

      // Master timeout with slave 0
      s_data0 = 8'h66;
      push(2'd0, 8'h66);
      s_req = 3'b001;
      tick();
      tick();
      check("mto_mreq", m_req, 1);
      tick(); tick(); tick();
      check("mto_hold", m_req, 1);
      check("mto_no_err_yet", terr, 0);
      tick();
      check("mto_mreq_drop", m_req, 0);
      check("mto_terr", terr, 1);
      check("mto_errid", err_id, 0);
      check("mto_grant", s_grant, 3'b001);
      s_req = 3'b000;
      tick();
      check("mto_release", s_grant, 0);
      check("mto_idle", busy, 0);
      check("mto_sticky", terr, 1);

      // Release timeout with slave 2 holding its request
      s_data2 = 8'h99;
      push(2'd2, 8'h99);
      s_req = 3'b100;
      wait_mreq("rto_mreq", 10);
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
      check("rto_grant", s_grant, 3'b100);
      tick(); tick(); tick();
      check("rto_grant_hold", s_grant, 3'b100);
      tick();
      check("rto_grant_drop", s_grant, 0);
      check("rto_errid", err_id, 2);
      check("rto_terr", terr, 1);
      check("rto_idle", busy, 0);
      s_req = 3'b000;
      tick();
      tick();
      check("rto_no_rearb", busy, 0);

      // Watchdog disabled: M_req held indefinitely
      s_data0 = 8'h3C;
      s_req_b = 3'b001;
      tick();
      tick();
      check("nowd_mreq", m_req_b, 1);
      check("nowd_mdata", m_data_b, 8'h3C);
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (i == 500) s_data0 = 8'hC3;
         if (i % 250 == 249) begin
            check("nowd_hold_mreq", m_req_b, 1);
            check("nowd_hold_mdata", m_data_b, 8'h3C);
            check("nowd_no_terr", terr_b, 0);
         end
      end
      check("nowd_mid", m_id_b, 0);
      check("nowd_no_grant", s_grant_b, 0);

      check("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
